// File: rtl/lrf_pkg.sv
// Shared constants and width helpers for the LRF multi-frame fuser.
package lrf_pkg;

    localparam logic LRF_MODE_MEAN = 1'b0;
    localparam logic LRF_MODE_MAX  = 1'b1;

    function automatic int lrf_acc_w(input int pixel_width, input int max_log2_fuse);
        return pixel_width + max_log2_fuse;
    endfunction

    function automatic int lrf_beats(input int image_dim, input int pixels_per_beat);
        return (image_dim * image_dim) / pixels_per_beat;
    endfunction

endpackage

// File: rtl/lrf_frame_fuser_if.sv
// AXI4-Stream bundle (data, valid, ready, last) shared by the fuser's input and output ports.
interface lrf_frame_fuser_if #(
    parameter int DATA_WIDTH = 128
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/lrf_frame_buf.sv
// Per-beat accumulator store: one write port, one synchronous read port whose data
// holds its last value while no read is issued.
module lrf_frame_buf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/lrf_frame_fuser.sv
// Fuses 2^k consecutive frames per pixel (rounded mean or max) into one output frame;
// S0 accepts a beat and reads its accumulator, S1 combines and writes back or emits.
module lrf_frame_fuser
    import lrf_pkg::*;
#(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int PIXEL_WIDTH     = 8,
    parameter int IMAGE_DIM       = 512,
    parameter int MAX_LOG2_FUSE   = 4,
    localparam int KW = (MAX_LOG2_FUSE > 0) ? $clog2(MAX_LOG2_FUSE + 1) : 1
) (
    input  logic              s_axis_aclk,
    input  logic              s_axis_aresetn,
    input  logic [KW-1:0]     cfg_log2_fuse,
    input  logic              cfg_mode,
    lrf_frame_fuser_if.slave  s_axis,
    lrf_frame_fuser_if.master m_axis,
    output logic              frame_err
);
    localparam int BEATS      = lrf_beats(IMAGE_DIM, PIXELS_PER_BEAT);
    localparam int ACC_W      = lrf_acc_w(PIXEL_WIDTH, MAX_LOG2_FUSE);
    localparam int DATA_WIDTH = PIXEL_WIDTH * PIXELS_PER_BEAT;
    localparam int AW         = $clog2(BEATS);
    localparam int FW         = (MAX_LOG2_FUSE > 0) ? MAX_LOG2_FUSE : 1;
    localparam logic [AW-1:0] LAST_BEAT = AW'(BEATS - 1);
    localparam logic [KW-1:0] K_MAX     = KW'(MAX_LOG2_FUSE);

    function automatic logic [PIXEL_WIDTH-1:0] pix_max(input logic [PIXEL_WIDTH-1:0] a,
                                                       input logic [PIXEL_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Round-half-up mean; the sum of 2^k pixels plus the half bias always fits ACC_W.
    function automatic logic [PIXEL_WIDTH-1:0] mean_round(input logic [ACC_W-1:0] sum,
                                                          input logic [KW-1:0]    k);
        logic [ACC_W-1:0] half;
        half = (ACC_W'(1) << k) >> 1;
        return PIXEL_WIDTH'((sum + half) >> k);
    endfunction

    logic [AW-1:0] beat_cnt_q;
    logic [FW-1:0] frame_idx_q;
    logic [KW-1:0] k_q;
    logic          mode_q;
    logic          vld_p1_q;
    logic          first_p1_q, last_p1_q, mode_p1_q;
    logic [AW-1:0] beat_p1_q;
    logic [KW-1:0] k_p1_q;
    logic [DATA_WIDTH-1:0] data_p1_q;
    logic                  m_tvalid_q, m_tlast_q, frame_err_q;
    logic [DATA_WIDTH-1:0] m_tdata_q;

    logic                  set_start, accept, s1_out, s1_adv, s_ready;
    logic [KW-1:0]         k_cur;
    logic                  mode_cur;
    logic [FW-1:0]         last_idx;
    logic [ACC_W*PIXELS_PER_BEAT-1:0] rd_data, wr_data;
    logic [DATA_WIDTH-1:0] fused;

    // Config is sampled only on the very first beat of a set; later beats reuse the latched copy.
    assign set_start = (frame_idx_q == '0) && (beat_cnt_q == '0);
    assign k_cur     = set_start ? ((cfg_log2_fuse > K_MAX) ? K_MAX : cfg_log2_fuse) : k_q;
    assign mode_cur  = set_start ? cfg_mode : mode_q;
    assign last_idx  = FW'((32'd1 << k_cur) - 32'd1);

    assign s1_out  = vld_p1_q && last_p1_q;
    assign s1_adv  = !vld_p1_q || !last_p1_q || !m_tvalid_q || m_axis.tready;
    assign s_ready = !vld_p1_q || s1_adv;
    assign accept  = s_axis.tvalid && s_ready;

    // ---- S0: accept, count, issue buffer read ----
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            beat_cnt_q  <= '0;
            frame_idx_q <= '0;
            k_q         <= '0;
            mode_q      <= LRF_MODE_MEAN;
            vld_p1_q    <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            m_tdata_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            if (accept) begin
                if (set_start) begin
                    k_q    <= k_cur;
                    mode_q <= mode_cur;
                end
                if (s_axis.tlast != (beat_cnt_q == LAST_BEAT)) frame_err_q <= 1'b1;
                if (beat_cnt_q == LAST_BEAT) begin
                    beat_cnt_q  <= '0;
                    frame_idx_q <= (frame_idx_q == last_idx) ? '0 : frame_idx_q + 1'b1;
                end else begin
                    beat_cnt_q <= beat_cnt_q + 1'b1;
                end
            end
            if (s1_adv) vld_p1_q <= accept;
            // ---- output register ----
            if (s1_out && s1_adv) begin
                m_tvalid_q <= 1'b1;
                m_tdata_q  <= fused;
                m_tlast_q  <= (beat_p1_q == LAST_BEAT);
            end else if (m_axis.tready) begin
                m_tvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (accept) begin
            data_p1_q  <= s_axis.tdata;
            beat_p1_q  <= beat_cnt_q;
            first_p1_q <= (frame_idx_q == '0);
            last_p1_q  <= (frame_idx_q == last_idx);
            k_p1_q     <= k_cur;
            mode_p1_q  <= mode_cur;
        end
    end

    lrf_frame_buf #(
        .DEPTH (BEATS),
        .WIDTH (ACC_W * PIXELS_PER_BEAT),
        .AW    (AW)
    ) u_buf (
        .clk_i     (s_axis_aclk),
        .rd_en_i   (accept),
        .rd_addr_i (beat_cnt_q),
        .rd_data_o (rd_data),
        .wr_en_i   (vld_p1_q && !last_p1_q),
        .wr_addr_i (beat_p1_q),
        .wr_data_i (wr_data)
    );

    // ---- S1: per-pixel combine; the first frame of a set ignores stale buffer data ----
    for (genvar i = 0; i < PIXELS_PER_BEAT; i++) begin : g_pix
        logic [ACC_W-1:0]       acc, sum;
        logic [PIXEL_WIDTH-1:0] px, pmax;
        assign acc  = first_p1_q ? '0 : rd_data[i*ACC_W +: ACC_W];
        assign px   = data_p1_q[i*PIXEL_WIDTH +: PIXEL_WIDTH];
        assign sum  = acc + ACC_W'(px);
        assign pmax = pix_max(acc[PIXEL_WIDTH-1:0], px);
        assign wr_data[i*ACC_W +: ACC_W] = (mode_p1_q == LRF_MODE_MAX) ? ACC_W'(pmax) : sum;
        assign fused[i*PIXEL_WIDTH +: PIXEL_WIDTH] =
            (mode_p1_q == LRF_MODE_MAX) ? pmax : mean_round(sum, k_p1_q);
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tlast  = m_tlast_q;
    assign frame_err     = frame_err_q;
endmodule

// File: tb/tb_lrf_frame_fuser.sv
// Directed bench for lrf_frame_fuser on a small 4x4 image, 4 pixels per beat (4 beats/frame).
module tb_lrf_frame_fuser;
    localparam int PPB = 4, PW = 8, DIM = 4, MAXK = 4;
    localparam int BEATS = DIM * DIM / PPB;
    localparam int DW = PPB * PW;
    localparam int KW = 3;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        int            cyc;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [KW-1:0] cfg_k;
    logic          cfg_mode;
    logic          frame_err;

    int n_checks = 0, n_fail = 0, cyc = 0, stall_viol = 0, rdy_mode = 0;
    int acc_cyc = 0, first_acc_cyc = 0;
    logic [DW-1:0] in_d [BEATS];
    logic [DW-1:0] a_d  [BEATS];
    logic [DW-1:0] exp_d[BEATS];
    int t2_vals[4] = '{10, 20, 30, 41};
    beat_t out_q[$];

    lrf_frame_fuser_if #(.DATA_WIDTH(DW)) s_if ();
    lrf_frame_fuser_if #(.DATA_WIDTH(DW)) m_if ();

    lrf_frame_fuser #(
        .PIXELS_PER_BEAT (PPB),
        .PIXEL_WIDTH     (PW),
        .IMAGE_DIM       (DIM),
        .MAX_LOG2_FUSE   (MAXK)
    ) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .cfg_log2_fuse  (cfg_k),
        .cfg_mode       (cfg_mode),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .frame_err      (frame_err)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0: m_if.tready = 1'b1;
            1: m_if.tready = 1'b0;
            default: m_if.tready = ($urandom_range(0, 9) >= 3);
        endcase
    end

    initial forever begin
        beat_t bt;
        @(negedge clk);
        if (m_if.tvalid && m_if.tready) begin
            bt.d = m_if.tdata; bt.l = m_if.tlast; bt.cyc = cyc;
            out_q.push_back(bt);
        end
        if (rst_n && !s_if.tready && !(m_if.tvalid && !m_if.tready)) stall_viol++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int t;
        t = 0;
        s_if.tdata = d; s_if.tlast = l; s_if.tvalid = 1'b1;
        @(negedge clk);
        while (!s_if.tready && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) check_val("accept_timeout", 1, 0);
        acc_cyc = cyc;
        @(posedge clk); #1;
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    endtask

    task automatic send_frame(input int inj, input bit drop_last);
        for (int b = 0; b < BEATS; b++) begin
            send_beat(in_d[b], ((b == BEATS-1) && !drop_last) || (b == inj));
            if (b == 0) first_acc_cyc = acc_cyc;
        end
    endtask

    task automatic fill_const(input logic [PW-1:0] px);
        for (int b = 0; b < BEATS; b++) in_d[b] = {PPB{px}};
    endtask

    task automatic fill_rand();
        for (int b = 0; b < BEATS; b++) in_d[b] = $urandom();
    endtask

    function automatic logic [DW-1:0] mean2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        for (int i = 0; i < PPB; i++)
            r[i*PW +: PW] = PW'(({1'b0, a[i*PW +: PW]} + {1'b0, b[i*PW +: PW]} + 9'd1) >> 1);
        return r;
    endfunction

    task automatic expect_frame(input string tag);
        int t;
        t = 0;
        while (out_q.size() < BEATS && t < 500) begin @(negedge clk); t++; end
        repeat (4) @(negedge clk);
        check_val({tag, "_nbeats"}, out_q.size(), BEATS);
        for (int b = 0; b < BEATS; b++) begin
            if (b < out_q.size()) begin
                check_val($sformatf("%s_data%0d", tag, b), out_q[b].d, exp_d[b]);
                check_val($sformatf("%s_last%0d", tag, b), out_q[b].l, (b == BEATS-1));
            end
        end
        out_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        int t;
        rst_n = 1'b0; cfg_k = '0; cfg_mode = 1'b0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_m_tvalid", m_if.tvalid, 0);
        check_val("rst_m_tdata", m_if.tdata, 0);
        check_val("rst_m_tlast", m_if.tlast, 0);
        check_val("rst_frame_err", frame_err, 0);
        check_val("rst_s_tready", s_if.tready, 1);
        @(posedge clk); #1;

        // k=2 mean of constant frames: (10+20+30+41+2)>>2 = 25
        cfg_k = 3'd2; cfg_mode = 1'b0;
        for (int f = 0; f < 4; f++) begin fill_const(PW'(t2_vals[f])); send_frame(-1, 0); end
        for (int b = 0; b < BEATS; b++) exp_d[b] = {PPB{8'd25}};
        expect_frame("mean_k2");

        // k=4 mean, all 255: full-scale accumulation must not overflow
        cfg_k = 3'd4;
        for (int f = 0; f < 16; f++) begin fill_const(8'd255); send_frame(-1, 0); end
        for (int b = 0; b < BEATS; b++) exp_d[b] = {PPB{8'd255}};
        expect_frame("mean_k4_full");

        // k requested 7 clamps to 4; max mode picks the single 200 frame
        cfg_k = 3'd7; cfg_mode = 1'b1;
        for (int f = 0; f < 16; f++) begin fill_const((f == 7) ? 8'd200 : 8'd0); send_frame(-1, 0); end
        for (int b = 0; b < BEATS; b++) exp_d[b] = {PPB{8'd200}};
        expect_frame("max_k4_clamp");

        // k=0: passthrough with 2-cycle latency
        cfg_k = 3'd0; cfg_mode = 1'b0;
        for (int f = 0; f < 2; f++) begin
            fill_rand();
            for (int b = 0; b < BEATS; b++) exp_d[b] = in_d[b];
            send_frame(-1, 0);
            if (f == 0) begin
                t = 0;
                while (out_q.size() == 0 && t < 50) begin @(negedge clk); t++; end
                if (out_q.size() > 0) check_val("k0_latency", out_q[0].cyc - first_acc_cyc, 2);
                else check_val("k0_latency_timeout", 1, 0);
            end
            expect_frame($sformatf("k0_pass%0d", f));
        end

        // k=1: frame 0 at full rate with output blocked, frame 1 under random backpressure
        cfg_k = 3'd1; rdy_mode = 1;
        fill_rand();
        for (int b = 0; b < BEATS; b++) a_d[b] = in_d[b];
        send_frame(-1, 0);
        check_val("k1_f0_full_rate", acc_cyc - first_acc_cyc, BEATS-1);
        rdy_mode = 2;
        fill_rand();
        for (int b = 0; b < BEATS; b++) exp_d[b] = mean2(a_d[b], in_d[b]);
        send_frame(-1, 0);
        expect_frame("k1_backpressure");
        rdy_mode = 0;
        check_val("k1_frame_err_clear", frame_err, 0);

        // spurious tlast on beat 1 of frame 0: error flag set, data path unaffected
        fill_rand();
        for (int b = 0; b < BEATS; b++) a_d[b] = in_d[b];
        send_frame(1, 0);
        check_val("tlast_err_set", frame_err, 1);
        fill_rand();
        for (int b = 0; b < BEATS; b++) exp_d[b] = mean2(a_d[b], in_d[b]);
        send_frame(-1, 0);
        expect_frame("tlast_err_data");
        check_val("frame_err_sticky", frame_err, 1);

        // reset mid frame 1 while an output beat is held
        rdy_mode = 1;
        fill_const(8'd1); send_frame(-1, 0);
        send_beat({PPB{8'd2}}, 1'b0);
        send_beat({PPB{8'd2}}, 1'b0);
        @(negedge clk);
        check_val("pend_m_tvalid", m_if.tvalid, 1);
        check_val("pend_s_tready_low", s_if.tready, 0);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_m_tvalid", m_if.tvalid, 0);
        check_val("async_rst_frame_err", frame_err, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        out_q.delete();
        rdy_mode = 0;
        fill_const(8'd100); send_frame(-1, 1);
        check_val("missing_tlast_err", frame_err, 1);
        fill_const(8'd51); send_frame(-1, 0);
        for (int b = 0; b < BEATS; b++) exp_d[b] = {PPB{8'd76}};
        expect_frame("post_reset");

        check_val("stall_only_when_blocked", stall_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
